// File: rtl/regfile_wb_scoreboard.sv
// Writeback arbiter, regfile write port and pending-register scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writebacks to decode operands.
`timescale 1ns/1ps
module regfile_wb_scoreboard #(
    parameter int NSRC          = 2,
    parameter bit RR_EN_DEFAULT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rs,
    input  logic [4:0]           issue_rt,
    input  logic [4:0]           issue_rd,
    output logic                 issue_stall,
    input  logic [NSRC-1:0]      wb_valid,
    input  logic [NSRC*5-1:0]    wb_rd,
    input  logic [NSRC*32-1:0]   wb_data,
    output logic [NSRC-1:0]      wb_ready,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_wdata,
    output logic [5:0]           pend_cnt,
    output logic                 wb_err,
    output logic                 fwd_rs_sel,
    output logic                 fwd_rt_sel,
    output logic [31:0]          fwd_rs_data,
    output logic [31:0]          fwd_rt_data
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [31:1]   pend_q;
    logic [31:0]   pend_vec;
    logic [PW-1:0] rr_ptr;
    logic [5:0]    cnt_q;
    logic          err_q;

    // Register 0 never becomes pending, so busy(r) is just a lookup.
    assign pend_vec = {pend_q, 1'b0};

    // Handshake: a requester raises wb_valid[i] and holds wb_rd/wb_data stable;
    // the transfer happens at the rising edge where wb_valid[i] & wb_ready[i].
    logic [NSRC-1:0] gnt;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [4:0]      g_rd;
    logic [31:0]     g_data;

    always_comb begin : arb
        int            src_i;
        logic [PW-1:0] src;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        src_i   = 0;
        src     = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (RR_EN_DEFAULT) src_i = (int'(rr_ptr) + k) % NSRC;
            else               src_i = k;
            src = PW'(src_i);
            if (!rst && !gnt_any && wb_valid[src]) begin
                gnt_any  = 1'b1;
                gnt[src] = 1'b1;
                gnt_idx  = src;
            end
        end
    end

    always_comb begin : wsel
        g_rd   = '0;
        g_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (gnt[k]) begin
                g_rd   = wb_rd[k*5 +: 5];
                g_data = wb_data[k*32 +: 32];
            end
        end
    end

    assign wb_ready = gnt;
    assign rf_rd    = g_rd;
    assign rf_wdata = g_data;

    logic rs_busy, rt_busy, rd_busy, rs_fwd, rt_fwd;
    assign rs_busy = pend_vec[issue_rs];
    assign rt_busy = pend_vec[issue_rt];
    assign rd_busy = pend_vec[issue_rd];

`ifdef REGFILE_WB_BYPASS_EN
    // An operand whose pending write lands this cycle is taken from the write port.
    assign rs_fwd = rs_busy & gnt_any & (g_rd == issue_rs);
    assign rt_fwd = rt_busy & gnt_any & (g_rd == issue_rt);
`else
    assign rs_fwd = 1'b0;
    assign rt_fwd = 1'b0;
`endif

    assign fwd_rs_sel  = rs_fwd;
    assign fwd_rt_sel  = rt_fwd;
    assign fwd_rs_data = rs_fwd ? g_data : 32'd0;
    assign fwd_rt_data = rt_fwd ? g_data : 32'd0;

    // rd is checked without forwarding: a WAW must wait for the clear to land.
    assign issue_stall = !rst && issue_valid &&
                         ((rs_busy && !rs_fwd) || (rt_busy && !rt_fwd) || rd_busy);

    logic set, clr, err_set;
    assign set     = issue_valid && !issue_stall && (issue_rd != 5'd0);
    assign clr     = gnt_any && (g_rd != 5'd0) && pend_vec[g_rd];
    assign err_set = gnt_any && (g_rd != 5'd0) && !pend_vec[g_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            rr_ptr <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (set && issue_rd == 5'(r))  pend_q[r] <= 1'b1;
                else if (clr && g_rd == 5'(r)) pend_q[r] <= 1'b0;
            end
            cnt_q <= cnt_q + {5'd0, set} - {5'd0, clr};
            if (err_set) err_q <= 1'b1;
            if (RR_EN_DEFAULT && gnt_any) rr_ptr <= PW'((int'(gnt_idx) + 1) % NSRC);
        end
    end

    assign pend_cnt = cnt_q;
    assign wb_err   = err_q;
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed cases, then random traffic checked
// every cycle against a set-of-pending-registers model.
`timescale 1ns/1ps
module tb_regfile_wb_scoreboard;
  localparam int NSRC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              issue_valid;
  logic [4:0]        issue_rs, issue_rt, issue_rd;
  logic              issue_stall;
  logic [NSRC-1:0]   wb_valid, wb_ready, wb_ready_fp;
  logic [NSRC*5-1:0] wb_rd;
  logic [NSRC*32-1:0] wb_data;
  logic [4:0]        rf_rd, rf_rd_fp;
  logic [31:0]       rf_wdata, rf_wdata_fp;
  logic [5:0]        pend_cnt, pend_cnt_fp;
  logic              wb_err, wb_err_fp, issue_stall_fp;
  logic              fwd_rs_sel, fwd_rt_sel, fwd_rs_sel_fp, fwd_rt_sel_fp;
  logic [31:0]       fwd_rs_data, fwd_rt_data, fwd_rs_data_fp, fwd_rt_data_fp;

  regfile_wb_scoreboard #(.NSRC(NSRC), .RR_EN_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pend_cnt(pend_cnt), .wb_err(wb_err),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data));

  // fixed-priority build sharing the same inputs
  regfile_wb_scoreboard #(.NSRC(NSRC), .RR_EN_DEFAULT(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs),
    .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_stall(issue_stall_fp),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready_fp),
    .rf_rd(rf_rd_fp), .rf_wdata(rf_wdata_fp), .pend_cnt(pend_cnt_fp), .wb_err(wb_err_fp),
    .fwd_rs_sel(fwd_rs_sel_fp), .fwd_rt_sel(fwd_rt_sel_fp),
    .fwd_rs_data(fwd_rs_data_fp), .fwd_rt_data(fwd_rt_data_fp));

  // requester state (drives the packed wb_* buses)
  bit          req_v [NSRC];
  logic [4:0]  req_rd [NSRC];
  logic [31:0] req_d [NSRC];

  // reference model: set of pending registers, sticky error, RR pointer
  bit mpend [32];
  bit merr = 1'b0;
  int mptr = 0;
  int last_gnt = -1;

  int n_checks = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_gnt(input bit rr);
    int s;
    if (rst) return -1;
    for (int k = 0; k < NSRC; k++) begin
      s = rr ? (mptr + k) % NSRC : k;
      if (req_v[s]) return s;
    end
    return -1;
  endfunction

  function automatic bit mbusy(input logic [4:0] r);
    return (r != 5'd0) && mpend[r];
  endfunction

  function automatic bit model_fwd(input logic [4:0] r, input int g);
`ifdef REGFILE_WB_BYPASS_EN
    return (g >= 0) && mbusy(r) && (req_rd[g] == r);
`else
    return (g < -100) && (r == 5'd31);
`endif
  endfunction

  function automatic bit model_stall(input int g);
    bit rs_b, rt_b;
    rs_b = mbusy(issue_rs) && !model_fwd(issue_rs, g);
    rt_b = mbusy(issue_rt) && !model_fwd(issue_rt, g);
    return !rst && issue_valid && (rs_b || rt_b || mbusy(issue_rd));
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(mpend[r]);
    return c;
  endfunction

  // model state update at the active edge
  always @(posedge clk) begin
    int g;
    bit st;
    logic [4:0] grd;
    g = model_gnt(1'b1);
    st = model_stall(g);
    if (rst) begin
      for (int r = 0; r < 32; r++) mpend[r] = 1'b0;
      merr = 1'b0;
      mptr = 0;
      last_gnt = -1;
    end else begin
      if (g >= 0) begin
        grd = req_rd[g];
        if (grd != 5'd0) begin
          if (mpend[grd]) mpend[grd] = 1'b0;
          else merr = 1'b1;
        end
        mptr = (g + 1) % NSRC;
      end
      if (issue_valid && !st && issue_rd != 5'd0) mpend[issue_rd] = 1'b1;
      last_gnt = g;
    end
  end

  // per-cycle compare, sampled on the falling edge
  always @(negedge clk) begin
    int g, gf;
    logic [4:0] grd, grd_f;
    logic [31:0] gd, gd_f;
    bit rsf, rtf;
    logic [NSRC-1:0] er, erf;
    g = model_gnt(1'b1);
    gf = model_gnt(1'b0);
    grd = (g >= 0) ? req_rd[g] : 5'd0;
    gd = (g >= 0) ? req_d[g] : 32'd0;
    grd_f = (gf >= 0) ? req_rd[gf] : 5'd0;
    gd_f = (gf >= 0) ? req_d[gf] : 32'd0;
    er = (g >= 0) ? NSRC'(1 << g) : '0;
    erf = (gf >= 0) ? NSRC'(1 << gf) : '0;
    rsf = model_fwd(issue_rs, g);
    rtf = model_fwd(issue_rt, g);
    chk("issue_stall", issue_stall, model_stall(g));
    chk("wb_ready", wb_ready, er);
    chk("rf_rd", rf_rd, grd);
    chk("rf_wdata", rf_wdata, gd);
    chk("pend_cnt", pend_cnt, model_cnt());
    chk("wb_err", wb_err, merr);
    chk("fwd_rs_sel", fwd_rs_sel, rsf);
    chk("fwd_rt_sel", fwd_rt_sel, rtf);
    chk("fwd_rs_data", fwd_rs_data, rsf ? gd : 32'd0);
    chk("fwd_rt_data", fwd_rt_data, rtf ? gd : 32'd0);
    chk("fp_wb_ready", wb_ready_fp, erf);
    chk("fp_rf_rd", rf_rd_fp, grd_f);
    chk("fp_rf_wdata", rf_wdata_fp, gd_f);
    // scoreboard of regfile writes in order
    if (g >= 0 && grd != 5'd0) exp_q.push_back({grd, gd});
    if (rf_rd != 5'd0) begin
      if (exp_q.size() == 0) chk("wr_log_extra", {rf_rd, rf_wdata}, 37'd0);
      else chk("wr_log", {rf_rd, rf_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic pack();
    wb_valid = {req_v[1], req_v[0]};
    wb_rd    = {req_rd[1], req_rd[0]};
    wb_data  = {req_d[1], req_d[0]};
  endtask

  task automatic set_wb(input int s, input bit v, input logic [4:0] rd, input logic [31:0] d);
    req_v[s] = v;
    req_rd[s] = rd;
    req_d[s] = d;
    pack();
  endtask

  task automatic set_issue(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    issue_valid = v;
    issue_rs = rs;
    issue_rt = rt;
    issue_rd = rd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle();
    int q[$];
    int r;
    cyc();
    rst = ($urandom_range(0, 149) == 0);
    for (int s = 0; s < NSRC; s++) begin
      if (rst) req_v[s] = 1'b0;
      else if (req_v[s] && last_gnt != s) req_v[s] = 1'b1;
      else if ($urandom_range(0, 2) == 0) begin
        q.delete();
        for (int k = 1; k < 32; k++) if (mpend[k]) q.push_back(k);
        r = $urandom_range(0, 9);
        req_v[s] = 1'b1;
        if (r < 7) req_rd[s] = (q.size() > 0) ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
        else if (r < 9) req_rd[s] = 5'($urandom_range(0, 31));
        else req_rd[s] = 5'd0;
        req_d[s] = $urandom;
      end else req_v[s] = 1'b0;
    end
    pack();
    set_issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
  endtask

  initial begin
    // reset with both requesters valid
    rst = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd1, 32'h11);
    set_wb(1, 1'b1, 5'd2, 32'h22);
    @(negedge clk);
    chk("rst_wb_ready", wb_ready, 2'b00);
    chk("rst_rf_rd", rf_rd, 5'd0);
    chk("rst_pend_cnt", pend_cnt, 6'd0);
    chk("rst_wb_err", wb_err, 1'b0);
    cyc();
    rst = 1'b0;
    set_wb(0, 1'b0, 5'd0, 32'd0);
    set_wb(1, 1'b0, 5'd0, 32'd0);
    set_issue(1'b1, 5'd0, 5'd0, 5'd5);
    @(negedge clk);
    chk("iss_rd5_stall", issue_stall, 1'b0);
    cyc();
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    @(negedge clk);
    chk("raw_rs5_stall", issue_stall, 1'b1);
    chk("raw_pend_cnt", pend_cnt, 6'd1);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd5, 32'h5);
    @(negedge clk);
    chk("clr5_ready", wb_ready, 2'b01);
    cyc();
    set_wb(0, 1'b0, 5'd0, 32'd0);

    // basic write
    set_issue(1'b1, 5'd0, 5'd0, 5'd8);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd8, 32'hDEADBEEF);
    @(negedge clk);
    chk("basic_ready", wb_ready, 2'b01);
    chk("basic_rf_rd", rf_rd, 5'd8);
    chk("basic_rf_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    set_wb(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("basic_pend_cnt", pend_cnt, 6'd0);

    // rd=0 writeback: consumed, no write, no error; brings rr_ptr back to 0
    set_wb(1, 1'b1, 5'd0, 32'hAAAA);
    @(negedge clk);
    chk("r0_ready", wb_ready, 2'b10);
    chk("r0_rf_rd", rf_rd, 5'd0);
    cyc();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("r0_no_err", wb_err, 1'b0);

    // round-robin versus fixed priority
    set_issue(1'b1, 5'd0, 5'd0, 5'd3);
    cyc();
    set_issue(1'b1, 5'd0, 5'd0, 5'd4);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd3, 32'h33);
    set_wb(1, 1'b1, 5'd4, 32'h44);
    @(negedge clk);
    chk("rr1_ready", wb_ready, 2'b01);
    chk("rr1_rf_rd", rf_rd, 5'd3);
    chk("fp1_ready", wb_ready_fp, 2'b01);
    cyc();
    set_wb(0, 1'b1, 5'd0, 32'h55);
    @(negedge clk);
    chk("rr2_ready", wb_ready, 2'b10);
    chk("rr2_rf_rd", rf_rd, 5'd4);
    chk("rr2_rf_wdata", rf_wdata, 32'h44);
    chk("fp2_ready", wb_ready_fp, 2'b01);
    cyc();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    cyc();
    set_wb(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("rr_pend_cnt", pend_cnt, 6'd0);

    // WAW with a same-cycle clear, then r0 operands
    set_issue(1'b1, 5'd0, 5'd0, 5'd9);
    cyc();
    set_wb(0, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("waw_stall", issue_stall, 1'b1);
    chk("waw_clr_ready", wb_ready, 2'b01);
    cyc();
    set_wb(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("waw_next_stall", issue_stall, 1'b0);
    cyc();
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("r0_ops_stall", issue_stall, 1'b0);
    chk("waw_pend_cnt", pend_cnt, 6'd1);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(0, 1'b1, 5'd9, 32'h999);
    cyc();

    // write to a non-pending register
    set_wb(0, 1'b1, 5'd12, 32'hC);
    @(negedge clk);
    chk("err_rf_rd", rf_rd, 5'd12);
    cyc();
    set_wb(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("err_set", wb_err, 1'b1);
    chk("err_pend_cnt", pend_cnt, 6'd0);
    cyc();
    @(negedge clk);
    chk("err_sticky", wb_err, 1'b1);

    // bypass of rs from the same-cycle writeback
    set_issue(1'b1, 5'd0, 5'd0, 5'd7);
    cyc();
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    set_wb(1, 1'b1, 5'd7, 32'h1234);
    @(negedge clk);
    chk("byp_rf_rd", rf_rd, 5'd7);
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_stall", issue_stall, 1'b0);
    chk("byp_fwd_sel", fwd_rs_sel, 1'b1);
    chk("byp_fwd_data", fwd_rs_data, 32'h1234);
`else
    chk("byp_stall", issue_stall, 1'b1);
    chk("byp_fwd_sel", fwd_rs_sel, 1'b0);
`endif
    cyc();
    set_wb(1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("byp_next_stall", issue_stall, 1'b0);
    cyc();

    // reset mid-operation drops pending marks and the error flag
    set_issue(1'b1, 5'd0, 5'd0, 5'd10);
    cyc();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pend_cnt", pend_cnt, 6'd0);
    chk("midrst_wb_err", wb_err, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) rand_cycle();
    cyc();
    rst = 1'b0;
    set_wb(0, 1'b0, 5'd0, 32'd0);
    set_wb(1, 1'b0, 5'd0, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("wr_log_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
